sample_loader: RTL and testbench
================================

# sample_loader

Input stage of the DFT datapath, directly upstream of the control FSM. Accepts a stream of signed samples over a valid/ready handshake and stores them in a private frame buffer. Once the configured frame length is captured, it raises `data_loaded`. When the FSM answers with `load_to_cache`, it copies the frame into the compute cache and signals `data_to_cache_loaded`.

## Interface
Parameters:
- `SAMPLE_W`, 16: sample width in bits, two's complement.
- `ADDR_W`, 12: buffer and cache address width; buffer depth is 2^ADDR_W.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  clock enable; when low, all state, counters and outputs hold.
- `sample_num`  in  12  frame length minus one; frame length L = `sample_num`+1, giving 1..4096.
- `s_valid`  in  1  input sample valid.
- `s_data`  in  SAMPLE_W  input sample.
- `s_ready`  out  1  loader accepts a sample this cycle.
- `load_to_cache`  in  1  FSM request to copy the frame into the cache (level).
- `data_loaded`  out  1  a full frame is buffered (level).
- `cache_we`  out  1  cache write strobe.
- `cache_addr`  out  ADDR_W  cache write address.
- `cache_data`  out  SAMPLE_W  cache write data.
- `data_to_cache_loaded`  out  1  copy complete; one-cycle pulse.

## Operation
- States:
  - CAPTURE: `s_ready`=`ce`. A sample is accepted on `s_valid`&`s_ready`. It is written to buffer[wr_cnt] and wr_cnt increments.
  - FULL: `data_loaded`=1, `s_ready`=0.
  - COPY: reads the buffer sequentially and writes each sample to the cache.
  - RELEASE: waits for the FSM to drop `load_to_cache`.
- Frame length: `sample_num` is latched into len_q on entry to CAPTURE, including the exit from reset. Changes to `sample_num` during a frame have no effect until the next frame.
- CAPTURE → FULL: on the acceptance of the sample written at address len_q. wr_cnt then clears to 0.
- FULL → COPY: on `load_to_cache`=1.
  - `load_to_cache` is ignored in CAPTURE, RELEASE and COPY.
  - If `load_to_cache` drops during COPY, the copy still completes.
- COPY: rd_cnt runs 0..len_q, one address per ce cycle.
  - Buffer read latency is 1 cycle.
  - `cache_addr` and `cache_data` are the read address and read data, each delayed one cycle.
  - `cache_we` = we_q & `ce`.
- COPY → RELEASE: on the ce cycle after the last cache write. `data_to_cache_loaded`=1 for exactly that cycle, and `data_loaded` drops in the same cycle.
- RELEASE → CAPTURE: on `load_to_cache`=0. len_q reloads and wr_cnt=0.
- Counters are ADDR_W+1 bits wide, so L=4096 terminates without wrap ambiguity. Data passes through unmodified, with no arithmetic.
- Reset values: state=CAPTURE, `s_ready`=0 during reset, `data_loaded`=0, `cache_we`=0, `cache_addr`=0, `cache_data`=0, `data_to_cache_loaded`=0, all counters 0.
- Reset mid-COPY aborts immediately. The cache contents are left partial; the FSM restarts on its own reset.

## Timing
- Capture rate: 1 sample per ce cycle.
- `data_loaded` rises the cycle after the last sample is accepted.
- From `load_to_cache` seen in FULL:
  - first `cache_we` appears 2 ce cycles later;
  - the last `cache_we` appears L+1 ce cycles later;
  - `data_to_cache_loaded` appears L+2 ce cycles later.
- All outputs are registered except `s_ready` and `cache_we`, which are ANDed with `ce`.

## Configuration
- Macro: `SAMPLE_LOADER_DROP_CNT_EN`.
- Defined:
  - adds output `drop_cnt` [7:0];
  - `drop_cnt` increments, saturating at 255, on every ce cycle with `s_valid`=1 and `s_ready`=0;
  - `drop_cnt` resets to 0 only on `rst`.
- Undefined: the port and its logic are absent, and dropped samples go uncounted.

## Structure
- Shared package `fft_pkg`: `SAMPLE_W`, `ADDR_W` defaults, `sample_t` typedef, and the `loader_state_t` enum (CAPTURE, FULL, COPY, RELEASE).
- Sub-module `sample_ram`: simple dual-port RAM with one write port and one read port, 1-cycle registered read, depth 2^ADDR_W, no reset on the storage array.

## Test plan
- `sample_num`=7, stream values 1..8 with `s_valid` held high:
  - `s_ready` drops after the 8th sample;
  - `data_loaded`=1 on the next cycle;
  - a 9th valid sample is not accepted.
- Frame full, pulse `load_to_cache`:
  - cache receives addr 0..7 = 1..8, first write 2 cycles later;
  - `data_to_cache_loaded` pulses once at cycle 10;
  - return to CAPTURE after `load_to_cache`=0.
- `sample_num`=0 with a single sample 0x8000:
  - one cache write at addr 0 with data 0x8000;
  - pulse 3 cycles after the request.
- `sample_num`=4095 with ramp 0..4095:
  - all 4096 cache writes in order;
  - no address wrap before completion.
- `ce` toggling 1/0 during CAPTURE and COPY: cycle counts stretch exactly by the number of ce-low cycles, and the cache contents are identical.
- Assert `rst` at the 3rd cache write:
  - all outputs go to 0 immediately;
  - after release, a new 4-sample frame captures and copies correctly.
- With `SAMPLE_LOADER_DROP_CNT_EN`: hold `s_valid` high for 300 cycles while in FULL, and `drop_cnt`=255.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the DFT datapath: default widths, the sample type
// and the state encoding used by the sample loader.
package fft_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int ADDR_W_DEF   = 12;

    typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        FULL    = 2'd1,
        COPY    = 2'd2,
        RELEASE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/sample_ram.sv
// Frame buffer: one write port, one read port with a registered read.
// Only the read register is reset; the storage array is not.
module sample_ram
    import fft_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Storage write.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // One-cycle registered read; holds when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sample_loader.sv
// Input stage of the DFT datapath: captures one frame of samples into a
// private buffer, then copies it into the compute cache on request.
// Optional build macro SAMPLE_LOADER_DROP_CNT_EN adds a saturating drop_cnt
// output counting samples offered while the loader was not ready.
//
//   state   | meaning
//   CAPTURE | accepting samples into buffer[wr_cnt]
//   FULL    | frame complete, data_loaded high, waiting for load_to_cache
//   COPY    | streaming buffer[0..len_q] into the cache
//   RELEASE | copy done, waiting for load_to_cache to drop
module sample_loader
    import fft_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [ADDR_W-1:0]   sample_num,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_data,
    output logic                s_ready,
    input  logic                load_to_cache,
    output logic                data_loaded,
    output logic                cache_we,
    output logic [ADDR_W-1:0]   cache_addr,
    output logic [SAMPLE_W-1:0] cache_data,
`ifdef SAMPLE_LOADER_DROP_CNT_EN
    output logic [7:0]          drop_cnt,
`endif
    output logic                data_to_cache_loaded
);

    loader_state_t state, state_nxt;

    logic [ADDR_W:0]   wr_cnt;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] len_cur;
    logic              reload_q;
    logic              we_q;
    logic              accept;
    logic              last_wr;
    logic              rd_active;
    logic              copy_done;

    // reload_q marks the first CAPTURE cycle of a frame, where sample_num is
    // taken directly so a sample accepted in that same cycle sees the new length.
    assign len_cur   = reload_q ? sample_num : len_q;
    assign s_ready   = (state == CAPTURE) && ce && !rst;
    assign accept    = s_valid && s_ready;
    assign last_wr   = accept && (wr_cnt == {1'b0, len_cur});
    assign rd_active = (state == COPY) && (rd_cnt <= {1'b0, len_q});
    // Reads finished: this is the cycle carrying the last cache write.
    assign copy_done = (state == COPY) && !rd_active;
    assign cache_we  = we_q && ce;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     state <= CAPTURE;
        else if (ce) state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            CAPTURE: if (last_wr)        state_nxt = FULL;
            FULL:    if (load_to_cache)  state_nxt = COPY;
            COPY:    if (copy_done)      state_nxt = RELEASE;
            RELEASE: if (!load_to_cache) state_nxt = CAPTURE;
            default:                     state_nxt = CAPTURE;
        endcase
    end

    // Counters, frame length and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt               <= '0;
            rd_cnt               <= '0;
            len_q                <= '0;
            reload_q             <= 1'b1;
            we_q                 <= 1'b0;
            cache_addr           <= '0;
            data_loaded          <= 1'b0;
            data_to_cache_loaded <= 1'b0;
        end else if (ce) begin
            if (state == CAPTURE && reload_q) begin
                len_q    <= sample_num;
                reload_q <= 1'b0;
            end
            if (accept) wr_cnt <= last_wr ? '0 : wr_cnt + 1'b1;
            if (rd_active) begin
                rd_cnt     <= rd_cnt + 1'b1;
                cache_addr <= rd_cnt[ADDR_W-1:0];
            end
            if (copy_done) rd_cnt <= '0;
            if (state == RELEASE && !load_to_cache) reload_q <= 1'b1;
            we_q <= rd_active;
            if (last_wr)        data_loaded <= 1'b1;
            else if (copy_done) data_loaded <= 1'b0;
            data_to_cache_loaded <= copy_done;
        end
    end

    // Buffer; its read register doubles as the cache data output.
    sample_ram #(
        .DATA_W (SAMPLE_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_cnt[ADDR_W-1:0]),
        .wr_data (s_data),
        .rd_en   (ce && rd_active),
        .rd_addr (rd_cnt[ADDR_W-1:0]),
        .rd_data (cache_data)
    );

`ifdef SAMPLE_LOADER_DROP_CNT_EN
    // Saturating count of samples offered while not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt <= '0;
        else if (ce && s_valid && !s_ready && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_sample_loader.sv
// Bench for sample_loader: random frames, lengths and ce patterns checked
// against an expected-frame queue and the documented ce-cycle timing.
module tb_sample_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [11:0] sample_num;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        load_to_cache;
    logic        data_loaded;
    logic        cache_we;
    logic [11:0] cache_addr;
    logic [15:0] cache_data;
    logic        data_to_cache_loaded;
`ifdef SAMPLE_LOADER_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] frame_q [$];
    logic [11:0] got_a [$];
    logic [15:0] got_d [$];

    sample_loader dut (
        .clk                  (clk),
        .rst                  (rst),
        .ce                   (ce),
        .sample_num           (sample_num),
        .s_valid              (s_valid),
        .s_data               (s_data),
        .s_ready              (s_ready),
        .load_to_cache        (load_to_cache),
        .data_loaded          (data_loaded),
        .cache_we             (cache_we),
        .cache_addr           (cache_addr),
        .cache_data           (cache_data),
`ifdef SAMPLE_LOADER_DROP_CNT_EN
        .drop_cnt             (drop_cnt),
`endif
        .data_to_cache_loaded (data_to_cache_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int len);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(16'($urandom));
    endtask

    // Stream frame_q in with s_valid held; loader must be in CAPTURE.
    task automatic do_capture(input int len, input bit ce_rand);
        int  idx = 0;
        int  ce_cyc = 0;
        int  guard = 0;
        bit  rdy_err = 0;
        bit  dl_err = 0;
        while (idx < len && guard < 4 * len + 50) begin
            step();
            ce            = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid       = 1'b1;
            s_data        = frame_q[idx];
            load_to_cache = ce_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (s_ready !== ce) rdy_err = 1;
            if (data_loaded !== 1'b0) dl_err = 1;
            if (ce) ce_cyc++;
            if (s_ready && s_valid) begin
                idx++;
                if (idx == 1) sample_num = 12'($urandom);
            end
            guard++;
        end
        check("cap_accepted", idx, len);
        check("cap_ready_eq_ce", rdy_err, 0);
        check("cap_loaded_low", dl_err, 0);
        check("cap_ce_cycles", ce_cyc, len);
        step();
        ce = 1'b1; s_valid = 1'b1; s_data = 16'h5A5A; load_to_cache = 1'b0;
        #1;
        check("full_loaded", data_loaded, 1);
        check("full_ready", s_ready, 0);
    endtask

    // Request a copy and check cache writes and timing in ce cycles.
    task automatic do_copy(input int len, input bit ce_rand);
        int  seen = 0;
        int  k;
        int  first_k = -1;
        int  last_k = -1;
        int  pulse_k = -1;
        int  errs = 0;
        bit  rdy_err = 0;
        bit  dl_err = 0;
        bit  dl_at_pulse = 1;
        bit  done = 0;
        got_a.delete();
        got_d.delete();
        step();
        ce = 1'b1; load_to_cache = 1'b1; s_valid = 1'b0;
        #1;
        for (int g = 0; g < 4 * len + 50 && !done; g++) begin
            step();
            ce            = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            load_to_cache = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid       = 1'($urandom_range(0, 1));
            s_data        = 16'($urandom);
            #1;
            k = seen + 1;
            if (s_ready) rdy_err = 1;
            if (cache_we) begin
                if (first_k < 0) first_k = k;
                last_k = k;
                got_a.push_back(cache_addr);
                got_d.push_back(cache_data);
            end
            if (data_to_cache_loaded) begin
                done = 1;
                pulse_k = k;
                dl_at_pulse = data_loaded;
            end else if (!data_loaded) dl_err = 1;
            if (ce) seen++;
        end
        check("copy_finished", done, 1);
        check("copy_n_writes", got_a.size(), len);
        for (int i = 0; i < got_a.size() && i < len; i++)
            if (got_a[i] !== 12'(i) || got_d[i] !== frame_q[i]) errs++;
        check("copy_content_errs", errs, 0);
        check("copy_first_we_k", first_k, 2);
        check("copy_last_we_k", last_k, len + 1);
        check("copy_pulse_k", pulse_k, len + 2);
        check("copy_loaded_drop", dl_at_pulse, 0);
        check("copy_loaded_hold", dl_err, 0);
        check("copy_ready_low", rdy_err, 0);
    endtask

    task automatic do_release();
        step();
        ce = 1'b1; load_to_cache = 1'b0; s_valid = 1'b0;
        #1;
        step();
        #1;
        check("rel_ready", s_ready, 1);
        check("rel_loaded", data_loaded, 0);
        check("rel_pulse", data_to_cache_loaded, 0);
    endtask

    initial begin
        int nw;
        int n;
        rst = 1'b1; ce = 1'b1; sample_num = 12'd7; s_valid = 1'b0;
        s_data = '0; load_to_cache = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", s_ready, 0);
        check("rst_loaded", data_loaded, 0);
        check("rst_we", cache_we, 0);
        check("rst_addr", cache_addr, 0);
        check("rst_data", cache_data, 0);
        check("rst_pulse", data_to_cache_loaded, 0);
`ifdef SAMPLE_LOADER_DROP_CNT_EN
        check("rst_drop", drop_cnt, 0);
`endif
        rst = 1'b0;

        frame_q.delete();
        for (int i = 1; i <= 8; i++) frame_q.push_back(16'(i));
        do_capture(8, 0);
        do_copy(8, 0);

        sample_num = 12'd0;
        do_release();
        frame_q.delete();
        frame_q.push_back(16'h8000);
        do_capture(1, 0);
        do_copy(1, 0);

        sample_num = 12'd4095;
        do_release();
        frame_q.delete();
        for (int i = 0; i < 4096; i++) frame_q.push_back(16'(i));
        do_capture(4096, 0);
        do_copy(4096, 0);

        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(0, 63);
            sample_num = 12'(n);
            do_release();
            fill_random(n + 1);
            do_capture(n + 1, f != 0);
            do_copy(n + 1, f != 0);
        end

        // Reset in the middle of a copy.
        sample_num = 12'd7;
        do_release();
        fill_random(8);
        do_capture(8, 0);
        step();
        ce = 1'b1; load_to_cache = 1'b1; s_valid = 1'b0;
        #1;
        nw = 0;
        for (int g = 0; g < 20 && nw < 3; g++) begin
            step();
            #1;
            if (cache_we) nw++;
        end
        check("rst_mid_third_we", nw, 3);
        rst = 1'b1;
        #1;
        check("rst_mid_we", cache_we, 0);
        check("rst_mid_addr", cache_addr, 0);
        check("rst_mid_data", cache_data, 0);
        check("rst_mid_loaded", data_loaded, 0);
        check("rst_mid_ready", s_ready, 0);
        check("rst_mid_pulse", data_to_cache_loaded, 0);
        sample_num = 12'd3;
        load_to_cache = 1'b0;
        step();
        step();
        rst = 1'b0;
        fill_random(4);
        do_capture(4, 0);
        do_copy(4, 0);

`ifdef SAMPLE_LOADER_DROP_CNT_EN
        sample_num = 12'd1;
        do_release();
        fill_random(2);
        do_capture(2, 0);
        for (int g = 0; g < 300; g++) begin
            step();
            ce = 1'b1; s_valid = 1'b1; load_to_cache = 1'b0;
        end
        #1;
        check("drop_sat", drop_cnt, 255);
        check("drop_still_full", data_loaded, 1);
        do_copy(2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
